// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side write bus of the FIFO write arbiter: one valid/data/last lane per requester
// plus the one-hot grant returned by the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned N    = 4,
  parameter int unsigned BITS = 16
);
  logic [N-1:0]      req;
  logic [N*BITS-1:0] req_data;
  logic [N-1:0]      req_last;
  logic [N-1:0]      grant;

  modport master (
    output req,
    output req_data,
    output req_last,
    input  grant
  );

  modport slave (
    input  req,
    input  req_data,
    input  req_last,
    output grant
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-capped arbiter that merges N write requesters into one FIFO write port
// and tracks FIFO occupancy so that grants stop while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned BITS      = 16,
  parameter int unsigned SIZE      = 128,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned OccW     = $clog2(SIZE),
  localparam int unsigned OwnW     = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned CntW     = $clog2(MAX_BURST + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_wr_arbiter_if.slave    bus,
  output logic                fifo_wr_en,
  output logic [BITS-1:0]     fifo_wr_data,
  input  logic                fifo_rd_en,
  output logic [OccW-1:0]     occupancy,
  output logic [OwnW-1:0]     owner,
  output logic                busy
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e            state_q, state_d;
  logic [OccW-1:0]   occ_q, occ_d;
  logic [OwnW-1:0]   owner_q, owner_d;
  logic [OwnW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              space_ok;
  logic              found;
  logic [OwnW-1:0]   win;
  logic [N-1:0]      grant_c;
  logic              accept;
  logic              acc_last;
  logic              rd_ok;
  logic [BITS-1:0]   wr_data_c;

  // Circular search starting just after the previous burst owner.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= int'(N); k++) begin
      idx = 32'(rr_ptr_q) + 32'(k);
      if (idx >= N) idx = idx - N;
      if (!found && bus.req[OwnW'(idx)]) begin
        found = 1'b1;
        win   = OwnW'(idx);
      end
    end
  end

  always_comb begin
    space_ok = (occ_q < OccW'(SIZE - 1));
    grant_c  = '0;
    // Grant is forced low during the reset cycle so nothing is written while state is stale.
    if (rst_n) begin
      unique case (state_q)
        StIdle:  if (space_ok && found) grant_c[win] = 1'b1;
        StBurst: grant_c[owner_q] = bus.req[owner_q] & space_ok;
        default: grant_c = '0;
      endcase
    end
  end

  always_comb begin
    wr_data_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant_c[i] && bus.req[i]) wr_data_c = wr_data_c | bus.req_data[i*BITS +: BITS];
    end
  end

  assign accept       = |(bus.req & grant_c);
  assign acc_last     = |(bus.req & grant_c & bus.req_last);
  assign rd_ok        = fifo_rd_en && (occ_q != '0);
  assign bus.grant    = grant_c;
  assign fifo_wr_en   = accept;
  assign fifo_wr_data = wr_data_c;
  assign occupancy    = occ_q;
  assign owner        = owner_q;
  assign busy         = (state_q == StBurst);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          owner_d = win;
          if (acc_last || (MAX_BURST == 1)) begin
            rr_ptr_d = win;
            cnt_d    = '0;
          end else begin
            state_d = StBurst;
            cnt_d   = CntW'(1);
          end
        end
      end
      StBurst: begin
        if (!bus.req[owner_q]) begin
          state_d  = StIdle;
          rr_ptr_d = owner_q;
          cnt_d    = '0;
        end else if (accept) begin
          if (acc_last || (cnt_q == CntW'(MAX_BURST - 1))) begin
            state_d  = StIdle;
            rr_ptr_d = owner_q;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        // A full FIFO with req held leaves the burst open.
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    unique case ({accept, rd_ok})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      occ_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= OwnW'(N - 1);
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      occ_q    <= occ_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, single word, round robin, burst cap,
// full/drain, read accounting, owner drop and mid-burst reset.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic        fifo_rd_en;
  logic [6:0]  occupancy;
  logic [1:0]  owner;
  logic        busy;

  int errors = 0;
  int checks = 0;

  fifo_wr_arbiter_if #(.N(4), .BITS(16)) bus_if ();

  fifo_wr_arbiter #(
    .N(4), .BITS(16), .SIZE(128), .MAX_BURST(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if.slave),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_rd_en   (fifo_rd_en),
    .occupancy    (occupancy),
    .owner        (owner),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus_if.req      = '0;
    bus_if.req_last = '0;
    bus_if.req_data = '0;
    fifo_rd_en      = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus_if.req      = '0;
    bus_if.req_last = '0;
    bus_if.req_data = '0;
    fifo_rd_en      = 1'b0;
    tick();
    tick();
    bus_if.req = 4'b1111;
    #1;
    checks++;
    if (bus_if.grant !== 4'b0000) begin
      errors++; $display("FAIL reset_grant: got %b want 0000", bus_if.grant);
    end
    checks++;
    if (fifo_wr_en !== 1'b0) begin
      errors++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en);
    end
    tick();
    bus_if.req = '0;
    rst_n      = 1'b1;
    #1;
    checks++;
    if (occupancy !== 7'd0) begin
      errors++; $display("FAIL reset_occ: got %0d want 0", occupancy);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus_if.req      = 4'b0001;
    bus_if.req_last = 4'b0001;
    bus_if.req_data = {48'h0, 16'h1234};
    #1;
    checks++;
    if (bus_if.grant !== 4'b0001) begin
      errors++; $display("FAIL single_grant: got %b want 0001", bus_if.grant);
    end
    checks++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 16'h1234) begin
      errors++;
      $display("FAIL single_wr: got en=%b data=%h want en=1 data=1234", fifo_wr_en, fifo_wr_data);
    end
    tick();
    bus_if.req = '0;
    #1;
    checks++;
    if (occupancy !== 7'd1) begin
      errors++; $display("FAIL single_occ: got %0d want 1", occupancy);
    end
    checks++;
    if (busy !== 1'b0 || fifo_wr_data !== 16'h0000) begin
      errors++;
      $display("FAIL single_idle: got busy=%b data=%h want busy=0 data=0000", busy, fifo_wr_data);
    end
  endtask

  task automatic test_round_robin_and_reads();
    logic [3:0]  exp_g;
    logic [15:0] exp_d;
    do_reset();
    bus_if.req      = 4'b1111;
    bus_if.req_last = 4'b1111;
    bus_if.req_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      exp_d = 16'hA000 + 16'(k % 4);
      #1;
      checks++;
      if (bus_if.grant !== exp_g || fifo_wr_data !== exp_d) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %b/%h want %b/%h", k, bus_if.grant, fifo_wr_data,
                 exp_g, exp_d);
      end
      tick();
    end
    bus_if.req = '0;
    #1;
    checks++;
    if (occupancy !== 7'd5) begin
      errors++; $display("FAIL rr_occ: got %0d want 5", occupancy);
    end
    // Accept and read in the same cycle cancel out.
    bus_if.req      = 4'b0001;
    fifo_rd_en      = 1'b1;
    #1;
    checks++;
    if (fifo_wr_en !== 1'b1) begin
      errors++; $display("FAIL both_wr_en: got %b want 1", fifo_wr_en);
    end
    tick();
    bus_if.req = '0;
    fifo_rd_en = 1'b0;
    #1;
    checks++;
    if (occupancy !== 7'd5) begin
      errors++; $display("FAIL both_occ: got %0d want 5", occupancy);
    end
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    #1;
    checks++;
    if (occupancy !== 7'd4) begin
      errors++; $display("FAIL read_occ: got %0d want 4", occupancy);
    end
    do_reset();
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    #1;
    checks++;
    if (occupancy !== 7'd0) begin
      errors++; $display("FAIL empty_read_occ: got %0d want 0", occupancy);
    end
  endtask

  task automatic test_burst_cap();
    do_reset();
    bus_if.req      = 4'b0100;
    bus_if.req_last = 4'b0000;
    bus_if.req_data = {16'h0, 16'hC2C2, 16'hB1B1, 16'h0};
    #1;
    checks++;
    if (bus_if.grant !== 4'b0100) begin
      errors++; $display("FAIL burst_first: got %b want 0100", bus_if.grant);
    end
    tick();
    bus_if.req = 4'b0110;
    for (int k = 1; k < 4; k++) begin
      #1;
      checks++;
      if (bus_if.grant !== 4'b0100 || busy !== 1'b1 || owner !== 2'd2) begin
        errors++;
        $display("FAIL burst_word[%0d]: got grant=%b busy=%b owner=%0d want 0100/1/2", k,
                 bus_if.grant, busy, owner);
      end
      tick();
    end
    #1;
    checks++;
    if (bus_if.grant !== 4'b0010 || busy !== 1'b0 || fifo_wr_data !== 16'hB1B1) begin
      errors++;
      $display("FAIL burst_handover: got grant=%b busy=%b data=%h want 0010/0/b1b1",
               bus_if.grant, busy, fifo_wr_data);
    end
    tick();
    bus_if.req = '0;
  endtask

  task automatic test_owner_drop();
    do_reset();
    bus_if.req      = 4'b0001;
    bus_if.req_last = 4'b0000;
    tick();
    bus_if.req = '0;
    #1;
    checks++;
    if (busy !== 1'b1 || bus_if.grant !== 4'b0000) begin
      errors++; $display("FAIL drop_hold: got busy=%b grant=%b want 1/0000", busy, bus_if.grant);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL drop_exit: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_full();
    int bad;
    do_reset();
    bad             = 0;
    bus_if.req      = 4'b0001;
    bus_if.req_last = 4'b0000;
    bus_if.req_data = {48'h0, 16'h5555};
    for (int i = 0; i < 127; i++) begin
      #1;
      if (bus_if.grant !== 4'b0001) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL fill_grants: got %0d missing grants want 0", bad);
    end
    #1;
    checks++;
    if (occupancy !== 7'd127) begin
      errors++; $display("FAIL full_occ: got %0d want 127", occupancy);
    end
    checks++;
    if (bus_if.grant !== 4'b0000 || fifo_wr_en !== 1'b0 || fifo_wr_data !== 16'h0000) begin
      errors++;
      $display("FAIL full_stall: got grant=%b en=%b data=%h want 0000/0/0000", bus_if.grant,
               fifo_wr_en, fifo_wr_data);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL full_busy: got %b want 1", busy);
    end
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    #1;
    checks++;
    if (occupancy !== 7'd126 || bus_if.grant !== 4'b0001 || fifo_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL drain_one: got occ=%0d grant=%b en=%b want 126/0001/1", occupancy,
               bus_if.grant, fifo_wr_en);
    end
    tick();
    bus_if.req = '0;
    #1;
    checks++;
    if (occupancy !== 7'd127 || busy !== 1'b0) begin
      errors++; $display("FAIL refill: got occ=%0d busy=%b want 127/0", occupancy, busy);
    end
  endtask

  task automatic test_mid_burst_reset();
    do_reset();
    bus_if.req      = 4'b1000;
    bus_if.req_last = 4'b0000;
    bus_if.req_data = {16'h3333, 32'h0, 16'h0F0F};
    tick();
    tick();
    checks++;
    if (owner !== 2'd3 || busy !== 1'b1 || occupancy !== 7'd2) begin
      errors++;
      $display("FAIL mid_state: got owner=%0d busy=%b occ=%0d want 3/1/2", owner, busy,
               occupancy);
    end
    rst_n      = 1'b0;
    bus_if.req = 4'b1001;
    #1;
    checks++;
    if (bus_if.grant !== 4'b0000 || fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_grant: got grant=%b en=%b want 0000/0", bus_if.grant, fifo_wr_en);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (occupancy !== 7'd0 || busy !== 1'b0 || bus_if.grant !== 4'b0001) begin
      errors++;
      $display("FAIL mid_after: got occ=%0d busy=%b grant=%b want 0/0/0001", occupancy, busy,
               bus_if.grant);
    end
    checks++;
    if (fifo_wr_data !== 16'h0F0F) begin
      errors++; $display("FAIL mid_data: got %h want 0f0f", fifo_wr_data);
    end
    tick();
    bus_if.req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin_and_reads();
    test_burst_cap();
    test_owner_drop();
    test_full();
    test_mid_burst_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning the number of write requesters (2..8).
REQ-002 SHALL have parameter BITS, default 16, meaning the data word width.
REQ-003 SHALL have parameter SIZE, default 128, meaning the attached FIFO depth (power of 2); usable capacity is SIZE-1 words.
REQ-004 SHALL have parameter MAX_BURST, default 4, meaning the maximum words one owner writes per grant (>=1).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port req, input, N bits: requester i has a word valid on req_data slice i.
REQ-008 SHALL have port req_data, input, N*BITS bits: slice i is bits [i*BITS +: BITS].
REQ-009 SHALL have port req_last, input, N bits: the current word of requester i ends its burst.
REQ-010 SHALL have port grant, output, N bits: one-hot or zero; word i is accepted in a cycle with req[i] & grant[i].
REQ-011 SHALL have port fifo_wr_en, output, 1 bit: drives the FIFO write enable.
REQ-012 SHALL have port fifo_wr_data, output, BITS bits: drives the FIFO write data.
REQ-013 SHALL have port fifo_rd_en, input, 1 bit: a copy of the FIFO read enable, used for occupancy tracking.
REQ-014 SHALL have port occupancy, output, $clog2(SIZE) bits: the words currently held in the FIFO.
REQ-015 SHALL have port owner, output, $clog2(N) bits (min 1): the index of the current burst owner; valid when busy.
REQ-016 SHALL have port busy, output, 1 bit: high while in state BURST.

Function
REQ-017 SHALL define space_ok = (occupancy < SIZE-1); no grant bit may be asserted while space_ok is low.
REQ-018 SHALL drive fifo_wr_en = |(req & grant) and fifo_wr_data = the accepted slice, combinationally in the accept cycle, with zero latency.
REQ-019 SHALL drive fifo_wr_data to 0 when fifo_wr_en is low.
REQ-020 SHALL update occupancy as follows: +1 on accept without counted read; -1 on fifo_rd_en && occupancy!=0 without accept; unchanged when both occur.
REQ-021 SHALL ignore fifo_rd_en while occupancy==0, matching the FIFO's empty-read behaviour.
REQ-022 SHALL implement state IDLE: if space_ok and any req, grant the first requester with req set, searching circularly from rr_ptr+1; else grant=0.
REQ-023 SHALL transition IDLE to BURST on an accept, setting owner=winner and burst_cnt=1, unless req_last or MAX_BURST==1 ends the burst immediately.
REQ-024 SHALL in state BURST drive grant[owner] = req[owner] & space_ok, with all other grant bits 0.
REQ-025 SHALL increment burst_cnt on each accept in BURST.
REQ-026 SHALL exit BURST to IDLE after the cycle in which the accepted word has req_last set or burst_cnt reaches MAX_BURST.
REQ-027 SHALL exit BURST to IDLE after any cycle in which req[owner]=0.
REQ-028 SHALL stay in BURST with grant=0 while space_ok is low and req[owner] is held; this does not end the burst.
REQ-029 SHALL set rr_ptr=owner on every burst end, including single-word bursts ended from IDLE.
REQ-030 SHALL make the next-cycle IDLE arbitration start after the previous owner, giving fairness.
REQ-031 SHALL treat req_data as don't-care when req=0.
REQ-032 SHALL never assert grant to two requesters in one cycle.

Reset
REQ-033 SHALL, on a rising clk edge with rst_n=0, set state=IDLE, occupancy=0, burst_cnt=0, owner=0, and rr_ptr=N-1, so requester 0 has first priority.
REQ-034 SHALL hold grant=0 and fifo_wr_en=0 during the reset cycle.
REQ-035 SHALL abandon any in-progress burst on reset; no partial-burst state survives.
REQ-036 SHALL be reset together with a drained FIFO, since occupancy=0 after reset must equal the FIFO fill.

Verification
REQ-037 Reset and single request: after reset, req=4'b0001 with data 0x1234 and req_last=1 -> grant=0001 and fifo_wr_en=1 with 0x1234 in the same cycle, occupancy=1 the next cycle.
REQ-038 Round-robin: req=4'b1111 held, req_last=1 on all -> grants 0,1,2,3,0 on consecutive cycles.
REQ-039 Burst cap: MAX_BURST=4, req[2] held with req_last=0 for 6 words, req[1] held -> four grants to 2, then 1 is granted.
REQ-040 Full: no reads, one requester streams -> 127 accepts, occupancy=127, grant=0; one fifo_rd_en pulse -> occupancy=126 and the next word is accepted.
REQ-041 Simultaneous accept and read at occupancy=5 -> occupancy stays 5; fifo_rd_en with occupancy=0 -> stays 0.
REQ-042 Mid-burst reset: owner=3 at burst_cnt=2 with rst_n=0 for one cycle -> IDLE, occupancy=0, and requester 0 wins next among req=4'b1001.
